wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback arbiter that sits directly upstream of the register file's single write port. It buffers results from two producers (source 0 = datapath/FMA result, source 1 = load/return path) in per-source FIFOs. It grants one result per cycle round-robin and drives the registered write-port signals wen/addr_w/data_w. Writes to register 0 are consumed but never issued, since register 0 is hardwired zero.

Parameters:
DATA_WIDTH, 32, result/register data width
ADDR_WIDTH, 5, register address width
FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
s0_valid  input  1  source 0 result valid
s0_ready  output  1  source 0 FIFO can accept
s0_addr  input  ADDR_WIDTH  source 0 destination register
s0_data  input  DATA_WIDTH  source 0 result
s1_valid  input  1  source 1 result valid
s1_ready  output  1  source 1 FIFO can accept
s1_addr  input  ADDR_WIDTH  source 1 destination register
s1_data  input  DATA_WIDTH  source 1 result
wen  output  1  register-file write enable (registered)
addr_w  output  ADDR_WIDTH  register-file write address (registered)
data_w  output  DATA_WIDTH  register-file write data (registered)
busy  output  1  any FIFO non-empty or wen high

Behaviour:
- Reset (rst high at a rising edge): both FIFOs empty, rr_ptr=0, wen=0, addr_w=0, data_w=0. s0_ready/s1_ready are 0 while rst is high. Inputs are ignored during reset. Reset mid-operation discards all buffered entries with no write issued.
- Push: an entry is accepted when sN_valid && sN_ready at a rising edge. sN_ready = !rst && (countN < FIFO_DEPTH). countN is registered, so ready has no combinational path from pop or from valid. A full FIFO deasserts ready even if it pops in the same cycle; ready reasserts the next cycle.
- A producer may hold valid with stable addr/data while ready is low. Per-source order is strictly FIFO.
- Arbitration, evaluated each cycle on the FIFO heads:
  - Both non-empty: grant the source indexed by rr_ptr; rr_ptr <= other source.
  - One non-empty: grant it; rr_ptr <= the non-granted source.
  - Neither non-empty: no grant; rr_ptr holds.
  - The granted head is popped at the same edge.
- Output register, at each edge:
  - With a grant: addr_w/data_w <= head addr/data; wen <= (head addr != 0).
  - Without a grant: wen <= 0; addr_w/data_w hold their previous values.
- Latency: an entry accepted at edge k into an empty FIFO with no contention drives wen high in the cycle after edge k+1, i.e. 2 edges from acceptance.
- Throughput: at most 1 write per cycle in total. Each source is guaranteed at least 1 grant in any 2 consecutive cycles while non-empty.
- Address 0: the entry is popped and consumes its grant slot; wen=0 for that slot; addr_w/data_w still update.
- Same destination from both sources: writes reach the register file in grant order. No merging or suppression.
- Count arithmetic:
  - Push and pop in the same cycle leave the count unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Count is log2(FIFO_DEPTH)+1 bits.
- busy = (count0 != 0) || (count1 != 0) || wen, combinational from registers.

Test Plan:
1. Reset, then s0 pushes addr=3, data=0x11 at edge 1 -> wen=1, addr_w=3, data_w=0x11 after edge 2 for one cycle; busy=0 after edge 3.
2. Both sources push at edge 1 (s0: 3/0x11, s1: 4/0x22), rr_ptr=0 -> writes 3/0x11 after edge 2, then 4/0x22 after edge 3. Repeat at edge 5 with 5/0x33 and 6/0x44: rr_ptr is now 0, so 5/0x33 first.
3. Both valid continuously for 10 cycles with incrementing data (s0 addrs 1.., s1 addrs 17..):
   - wen stays high every cycle after the first two.
   - Grants alternate s0/s1.
   - Each sN_ready drops once its FIFO reaches 2 entries.
   - No entry is lost or reordered; all 20 values are checked in order per source.
4. s1 pushes addr=0, data=0xDEAD, then addr=7, data=0xBEEF -> no wen in the first grant slot; wen=1 with 7/0xBEEF in the next slot.
5. Fill both FIFOs (4 entries), assert rst for one edge mid-stream -> wen=0, readies low during reset. After reset: readies=1, busy=0, no stale write appears.
6. Single source with a FIFO_DEPTH=4 build, pushing every cycle -> ready never drops; wen is continuous at 1 write/cycle with 2-edge latency.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter feeding the register file's single write port. Results from
// two producers are buffered in one small FIFO per source. Each cycle one FIFO
// head is granted round-robin and turned into a registered write. Writes whose
// destination is register 0 use up their grant slot but never raise wen,
// because register 0 is hardwired to zero.
//
// Handshake (both sources): a result transfers on a rising edge where
// sN_valid && sN_ready. A producer that sees ready low keeps valid, addr and
// data stable until the transfer happens. sN_ready depends only on rst and on
// the registered fill count, so it never depends combinationally on valid or
// on a pop in the same cycle.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   s0_valid/ready/addr/data   source 0 (datapath / FMA result)
//   s1_valid/ready/addr/data   source 1 (load / return path)
//   wen, addr_w, data_w  registered register-file write port
//   busy                 high while any FIFO holds an entry or wen is high
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Per-source FIFO storage and bookkeeping, indexed [source][entry].
    logic [ADDR_WIDTH-1:0] addr_mem_q [2][FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_d [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [2][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [2];
    logic [PTR_W-1:0]      wr_ptr_d [2];
    logic [PTR_W-1:0]      rd_ptr_q [2];
    logic [PTR_W-1:0]      rd_ptr_d [2];
    logic [CNT_W-1:0]      count_q [2];
    logic [CNT_W-1:0]      count_d [2];

    // Arbitration and output registers.
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;

    // Source-indexed views of the input ports.
    logic [1:0]            in_valid;
    logic [1:0]            in_ready;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0] in_data [2];

    logic [1:0]            not_empty;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic                  grant;
    logic                  grant_sel;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign in_valid   = {s1_valid, s0_valid};
    assign in_addr[0] = s0_addr;
    assign in_addr[1] = s1_addr;
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;

    // Ready is taken from the registered count only: a full FIFO stays
    // not-ready for the cycle in which it pops.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < 2; i++) begin
            in_ready[i] = !rst && (count_q[i] < DEPTH_C);
        end
    end

    assign s0_ready = in_ready[0];
    assign s1_ready = in_ready[1];

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        wen_d      = 1'b0;
        addr_w_d   = addr_w_q;
        data_w_d   = data_w_q;
        grant      = 1'b0;
        grant_sel  = 1'b0;
        pop        = '0;
        push       = '0;
        not_empty  = '0;

        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (count_q[i] != '0);
        end

        // rr_ptr names the source that wins when both heads are present; after
        // any grant it points at the source that was not granted.
        if (not_empty[0] && not_empty[1]) begin
            grant     = 1'b1;
            grant_sel = rr_ptr_q;
            rr_ptr_d  = ~rr_ptr_q;
        end else if (not_empty[0]) begin
            grant     = 1'b1;
            grant_sel = 1'b0;
            rr_ptr_d  = 1'b1;
        end else if (not_empty[1]) begin
            grant     = 1'b1;
            grant_sel = 1'b1;
            rr_ptr_d  = 1'b0;
        end

        if (grant) begin
            pop[grant_sel] = 1'b1;
        end

        head_addr = addr_mem_q[grant_sel][rd_ptr_q[grant_sel]];
        head_data = data_mem_q[grant_sel][rd_ptr_q[grant_sel]];

        for (int i = 0; i < 2; i++) begin
            push[i] = in_valid[i] && in_ready[i];
            if (push[i]) begin
                addr_mem_d[i][wr_ptr_q[i]] = in_addr[i];
                data_mem_d[i][wr_ptr_q[i]] = in_data[i];
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end

        // A register-0 entry still updates addr_w/data_w; it only keeps wen low.
        if (grant) begin
            addr_w_d = head_addr;
            data_w_d = head_data;
            wen_d    = (head_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q <= 1'b0;
            wen_q    <= 1'b0;
            addr_w_q <= '0;
            data_w_q <= '0;
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            wen_q      <= wen_d;
            addr_w_q   <= addr_w_d;
            data_w_q   <= data_w_d;
        end
    end

    assign wen    = wen_q;
    assign addr_w = addr_w_q;
    assign data_w = data_w_q;
    assign busy   = (count_q[0] != '0) || (count_q[1] != '0) || wen_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Bench for wb_arbiter. Main instance uses FIFO_DEPTH=2; a second instance with
// FIFO_DEPTH=4 covers single-source streaming. Accepted non-zero-address
// entries are queued per source and matched against register-file writes; the
// directed sequences add cycle-exact checks on grant order and latency.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // ---------------- DUT (depth 2) ----------------
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic          s0_ready, s1_ready;
    logic [AW-1:0] s0_addr = '0, s1_addr = '0;
    logic [DW-1:0] s0_data = '0, s1_data = '0;
    logic          wen, busy;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] data_w;

    wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .wen(wen), .addr_w(addr_w), .data_w(data_w), .busy(busy)
    );

    // ---------------- DUT (depth 4) ----------------
    logic          t_valid = 1'b0, t1_valid = 1'b0;
    logic          t_ready, t1_ready;
    logic [AW-1:0] t_addr = '0, t1_addr = '0;
    logic [DW-1:0] t_data = '0, t1_data = '0;
    logic          t_wen, t_busy;
    logic [AW-1:0] t_addr_w;
    logic [DW-1:0] t_data_w;

    wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s0_valid(t_valid), .s0_ready(t_ready), .s0_addr(t_addr), .s0_data(t_data),
        .s1_valid(t1_valid), .s1_ready(t1_ready), .s1_addr(t1_addr), .s1_data(t1_data),
        .wen(t_wen), .addr_w(t_addr_w), .data_w(t_data_w), .busy(t_busy)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [AW+DW-1:0] exp_q0[$];
    logic [AW+DW-1:0] exp_q1[$];

    // Inputs change just after rising edges, so at the falling edge valid/ready
    // show what the next edge will accept, and wen/addr_w/data_w are stable.
    always @(negedge clk) begin
        logic [AW+DW-1:0] got;
        logic [AW+DW-1:0] want;
        if (wen === 1'b1) begin
            got = {addr_w, data_w};
            if (exp_q0.size() > 0 && exp_q0[0][AW+DW-1:DW] == addr_w) begin
                want = exp_q0.pop_front();
            end else if (exp_q1.size() > 0) begin
                want = exp_q1.pop_front();
            end else begin
                want = '0;
            end
            check_eq("sb_write", 64'(got), 64'(want));
        end
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (s0_valid && s0_ready && s0_addr != '0) exp_q0.push_back({s0_addr, s0_data});
            if (s1_valid && s1_ready && s1_addr != '0) exp_q1.push_back({s1_addr, s1_data});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Holds rst for one edge; ready must be low while rst is high.
    task automatic do_reset();
        rst = 1'b1;
        neg();
        check_eq("rst_s0_ready", 64'(s0_ready), 64'(0));
        check_eq("rst_s1_ready", 64'(s1_ready), 64'(0));
        step();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        t_valid  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx0, idx1;
        logic acc0, acc1, low0, low1;

        step();

        // 1: reset state, then single push with 2-edge latency
        do_reset();
        neg();
        check_eq("reset_wen", 64'(wen), 64'(0));
        check_eq("reset_addr_w", 64'(addr_w), 64'(0));
        check_eq("reset_data_w", 64'(data_w), 64'(0));
        check_eq("reset_busy", 64'(busy), 64'(0));
        check_eq("reset_s0_ready", 64'(s0_ready), 64'(1));
        check_eq("reset_s1_ready", 64'(s1_ready), 64'(1));
        check_eq("reset_t_wen", 64'(t_wen), 64'(0));
        step();
        s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h11;
        step();
        idle_inputs();
        neg();
        check_eq("t1_wen_early", 64'(wen), 64'(0));
        check_eq("t1_busy", 64'(busy), 64'(1));
        step();
        neg();
        check_eq("t1_wen", 64'(wen), 64'(1));
        check_eq("t1_addr_w", 64'(addr_w), 64'(3));
        check_eq("t1_data_w", 64'(data_w), 64'(32'h11));
        step();
        neg();
        check_eq("t1_wen_drop", 64'(wen), 64'(0));
        check_eq("t1_busy_idle", 64'(busy), 64'(0));
        check_eq("t1_addr_hold", 64'(addr_w), 64'(3));

        // 2: both sources at once, round-robin from rr_ptr=0
        step();
        do_reset();
        s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h11;
        s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h22;
        step();
        idle_inputs();
        step();
        neg();
        check_eq("t2_first", 64'({wen, addr_w, data_w}), 64'({1'b1, 5'd3, 32'h11}));
        step();
        neg();
        check_eq("t2_second", 64'({wen, addr_w, data_w}), 64'({1'b1, 5'd4, 32'h22}));
        step();
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h33;
        s1_valid = 1'b1; s1_addr = 5'd6; s1_data = 32'h44;
        neg();
        check_eq("t2_gap_wen", 64'(wen), 64'(0));
        step();
        idle_inputs();
        step();
        neg();
        check_eq("t2_third", 64'({wen, addr_w, data_w}), 64'({1'b1, 5'd5, 32'h33}));
        step();
        neg();
        check_eq("t2_fourth", 64'({wen, addr_w, data_w}), 64'({1'b1, 5'd6, 32'h44}));
        step();
        neg();
        check_eq("t2_idle_busy", 64'(busy), 64'(0));

        // 3: both sources streaming, alternating grants, back-pressure
        step();
        do_reset();
        idx0 = 0; idx1 = 0; low0 = 1'b0; low1 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            s0_valid = (idx0 < 10); s0_addr = AW'(1 + idx0);  s0_data = 32'h100 + 32'(idx0);
            s1_valid = (idx1 < 10); s1_addr = AW'(17 + idx1); s1_data = 32'h200 + 32'(idx1);
            neg();
            if (cyc >= 2 && cyc < 22) begin
                check_eq("t3_wen", 64'(wen), 64'(1));
                check_eq("t3_src", 64'(data_w[9:8]), (cyc % 2 == 0) ? 64'(1) : 64'(2));
            end
            if (cyc == 22) check_eq("t3_wen_end", 64'(wen), 64'(0));
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            if (s0_valid && !s0_ready) low0 = 1'b1;
            if (s1_valid && !s1_ready) low1 = 1'b1;
            step();
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        idle_inputs();
        check_eq("t3_s0_all_pushed", 64'(idx0), 64'(10));
        check_eq("t3_s1_all_pushed", 64'(idx1), 64'(10));
        check_eq("t3_s0_ready_dropped", 64'(low0), 64'(1));
        check_eq("t3_s1_ready_dropped", 64'(low1), 64'(1));
        check_eq("t3_drain", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

        // 4: register 0 consumes a slot without a write
        do_reset();
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hDEAD;
        step();
        s1_addr = 5'd7; s1_data = 32'hBEEF;
        step();
        idle_inputs();
        neg();
        check_eq("t4_zero_wen", 64'(wen), 64'(0));
        check_eq("t4_zero_addr_w", 64'(addr_w), 64'(0));
        check_eq("t4_zero_data_w", 64'(data_w), 64'(32'hDEAD));
        step();
        neg();
        check_eq("t4_next", 64'({wen, addr_w, data_w}), 64'({1'b1, 5'd7, 32'hBEEF}));

        // 5: reset mid-stream discards buffered entries
        step();
        do_reset();
        idx0 = 0; idx1 = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            s0_valid = 1'b1; s0_addr = AW'(8 + idx0);  s0_data = 32'h500 + 32'(idx0);
            s1_valid = 1'b1; s1_addr = AW'(24 + idx1); s1_data = 32'h600 + 32'(idx1);
            neg();
            acc0 = s0_ready;
            acc1 = s1_ready;
            step();
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        check_eq("t5_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        neg();
        check_eq("t5_rst_s0_ready", 64'(s0_ready), 64'(0));
        check_eq("t5_rst_s1_ready", 64'(s1_ready), 64'(0));
        step();
        rst = 1'b0;
        idle_inputs();
        neg();
        check_eq("t5_wen", 64'(wen), 64'(0));
        check_eq("t5_busy", 64'(busy), 64'(0));
        check_eq("t5_s0_ready", 64'(s0_ready), 64'(1));
        check_eq("t5_s1_ready", 64'(s1_ready), 64'(1));
        check_eq("t5_addr_w", 64'(addr_w), 64'(0));
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            neg();
            check_eq("t5_no_stale", 64'(wen), 64'(0));
        end

        // 6: depth-4 build, single source every cycle
        step();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            t_valid = (c < 10);
            t_addr  = AW'(8 + c);
            t_data  = 32'hA000 + 32'(c);
            neg();
            if (t_valid) check_eq("t6_ready", 64'(t_ready), 64'(1));
            if (c >= 2) begin
                check_eq("t6_wen", 64'(t_wen), 64'(1));
                check_eq("t6_write", 64'({t_addr_w, t_data_w}),
                         64'({AW'(8 + c - 2), 32'hA000 + 32'(c - 2)}));
            end
            step();
        end
        idle_inputs();
        neg();
        check_eq("t6_wen_end", 64'(t_wen), 64'(0));
        check_eq("t6_busy_end", 64'(t_busy), 64'(0));
        check_eq("final_drain", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
